// File: rtl/matrix_pkg.sv
// Shared types for matrix_stream_loader: FSM states, matrix shape codes,
// buffer selects, response codes and the tile shape helper.
package matrix_pkg;

    localparam int DIM_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_TYPE,
        ST_CFG_MUL,
        ST_CFG_ADD,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_LOAD_C,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        MT_M8N32   = 2'd0,
        MT_M16N16  = 2'd1,
        MT_M32N8   = 2'd2,
        MT_ILLEGAL = 2'd3
    } mtype_e;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [DIM_W-1:0] m;
        logic [DIM_W-1:0] n;
    } shape_t;

    // M grows and N shrinks with the type code so M*N stays constant.
    function automatic shape_t tile_shape(input mtype_e t, input int base);
        shape_t s;
        s.m = DIM_W'(base << t);
        s.n = DIM_W'((4 * base) >> t);
        return s;
    endfunction

endpackage

// File: rtl/matrix_addr_gen.sv
// matrix_addr_gen: blk/row/col element counters and buffer address for one operand tile.
// Latency: address and last flag are combinational from the counters; counters step on advance.
// Backpressure: counters hold whenever advance is low; clear has priority over advance.
module matrix_addr_gen
    import matrix_pkg::*;
#(
    parameter int NUM_BLK = 4,
    parameter int ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              advance,
    input  logic              col_major,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int BLK_W = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;

    logic [BLK_W-1:0] blk;
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic             col_last;
    logic             row_last;
    logic             blk_last;
    logic [DIM_W-1:0] tile_sz;
    logic [DIM_W-1:0] offset;

    assign col_last = (col == cols - 1'b1);
    assign row_last = (row == rows - 1'b1);
    assign blk_last = (blk == BLK_W'(NUM_BLK - 1));
    assign last     = blk_last && row_last && col_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk <= '0;
            row <= '0;
            col <= '0;
        end else if (clear) begin
            blk <= '0;
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                if (row_last) begin
                    row <= '0;
                    blk <= blk_last ? '0 : blk + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Stream order is always row-major; col_major only changes where the element lands.
    assign tile_sz = rows * cols;
    assign offset  = col_major ? (col * rows + row) : (row * cols + col);
    assign addr    = ADDR_W'(DIM_W'(blk) * tile_sz + offset);

endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: parses a 3-beat header then writes the A/B/C tiles into the operand buffer.
// Latency: accepted beat -> buf_we/addr/data one cycle later; done one cycle after the response handshake.
// Backpressure: s_wready high only in CFG/LOAD states, s_wvalid gaps stall; RESP holds until s_bready.
// Build option: MATRIX_LOADER_TRANSPOSE_B_EN stores B column-major within each block.
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int  DATA_W  = 32,
    parameter int  BASE    = 8,
    parameter int  K_DIM   = 16,
    parameter int  NUM_BLK = 4,
    localparam int ADDR_W  = $clog2(NUM_BLK * 4 * BASE * K_DIM)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [1:0]        mat_type,
    output logic [5:0]        mul_prec,
    output logic [5:0]        add_prec,
    output logic              buf_we,
    output logic [1:0]        buf_sel,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata
);

`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
    localparam logic TRANSPOSE_B = 1'b1;
`else
    localparam logic TRANSPOSE_B = 1'b0;
`endif

    state_e            state;
    state_e            state_nxt;
    shape_t            shape;
    logic              accept;
    logic              in_load;
    logic              last_beat;
    logic              col_major;
    logic [1:0]        cur_sel;
    logic [DIM_W-1:0]  rows;
    logic [DIM_W-1:0]  cols;
    logic [ADDR_W-1:0] gen_addr;

    assign shape   = tile_shape(mtype_e'(mat_type), BASE);
    assign accept  = s_wvalid && s_wready;
    assign in_load = (state == ST_LOAD_A) || (state == ST_LOAD_B) || (state == ST_LOAD_C);

    always_comb begin
        rows      = shape.m;
        cols      = DIM_W'(K_DIM);
        cur_sel   = SEL_A;
        col_major = 1'b0;
        case (state)
            ST_LOAD_B: begin
                rows      = DIM_W'(K_DIM);
                cols      = shape.n;
                cur_sel   = SEL_B;
                col_major = TRANSPOSE_B;
            end
            ST_LOAD_C: begin
                rows    = shape.m;
                cols    = shape.n;
                cur_sel = SEL_C;
            end
            default: ;
        endcase
    end

    matrix_addr_gen #(
        .NUM_BLK (NUM_BLK),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rstn      (rstn),
        .clear     ((state == ST_IDLE) && start),
        .advance   (accept && in_load),
        .col_major (col_major),
        .rows      (rows),
        .cols      (cols),
        .addr      (gen_addr),
        .last      (last_beat)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CFG_TYPE;
                end
            end
            ST_CFG_TYPE: begin
                s_wready = 1'b1;
                if (accept) begin
                    state_nxt = (mtype_e'(s_wdata[1:0]) == MT_ILLEGAL) ? ST_RESP : ST_CFG_MUL;
                end
            end
            ST_CFG_MUL: begin
                s_wready = 1'b1;
                if (accept) begin
                    state_nxt = ST_CFG_ADD;
                end
            end
            ST_CFG_ADD: begin
                s_wready = 1'b1;
                if (accept) begin
                    state_nxt = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                s_wready = 1'b1;
                if (accept && last_beat) begin
                    state_nxt = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                s_wready = 1'b1;
                if (accept && last_beat) begin
                    state_nxt = ST_LOAD_C;
                end
            end
            ST_LOAD_C: begin
                s_wready = 1'b1;
                if (accept && last_beat) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Config registers deliberately survive start; only a new header beat overwrites them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mat_type  <= '0;
            mul_prec  <= '0;
            add_prec  <= '0;
            s_bresp   <= RESP_OKAY;
            done      <= 1'b0;
            buf_we    <= 1'b0;
            buf_sel   <= '0;
            buf_addr  <= '0;
            buf_wdata <= '0;
        end else begin
            done   <= (state == ST_RESP) && s_bready;
            buf_we <= accept && in_load;
            if (accept && (state == ST_CFG_TYPE)) begin
                mat_type <= s_wdata[1:0];
                s_bresp  <= (mtype_e'(s_wdata[1:0]) == MT_ILLEGAL) ? RESP_SLVERR : RESP_OKAY;
            end
            if (accept && (state == ST_CFG_MUL)) begin
                mul_prec <= s_wdata[5:0];
            end
            if (accept && (state == ST_CFG_ADD)) begin
                add_prec <= s_wdata[5:0];
            end
            if (accept && in_load) begin
                buf_sel   <= cur_sel;
                buf_addr  <= gen_addr;
                buf_wdata <= s_wdata;
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: a nested-loop tile model predicts every buffer write,
// a negedge monitor compares each write, and directed checks pin counts, addresses and handshakes.
module tb_matrix_stream_loader;

    localparam int DATA_W  = 32;
    localparam int BASE    = 8;
    localparam int K_DIM   = 16;
    localparam int NUM_BLK = 4;
    localparam int ADDR_W  = 11;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] s_wdata = '0;
    logic              s_wvalid = 1'b0;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready = 1'b0;
    logic [1:0]        mat_type;
    logic [5:0]        mul_prec;
    logic [5:0]        add_prec;
    logic              buf_we;
    logic [1:0]        buf_sel;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;

    matrix_stream_loader #(
        .DATA_W  (DATA_W),
        .BASE    (BASE),
        .K_DIM   (K_DIM),
        .NUM_BLK (NUM_BLK)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .s_wdata   (s_wdata),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .mat_type  (mat_type),
        .mul_prec  (mul_prec),
        .add_prec  (add_prec),
        .buf_we    (buf_we),
        .buf_sel   (buf_sel),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               exp_q[$];
    logic [ADDR_W-1:0] b_log[$];
    int                n_checks = 0;
    int                n_errors = 0;
    int                cnt[3];
    logic [ADDR_W-1:0] first_addr[3];
    logic [ADDR_W-1:0] last_addr[3];
    int                done_cnt = 0;
    bit                mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string detail);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic clear_stats();
        foreach (cnt[i]) begin
            cnt[i]        = 0;
            first_addr[i] = '0;
            last_addr[i]  = '0;
        end
        done_cnt = 0;
        exp_q.delete();
        b_log.delete();
    endtask

    // Expected writes straight from the tile definitions: A is MxK, B is KxN, C is MxN.
    task automatic build_model(input logic [1:0] t, input logic [31:0] dbase);
        int m;
        int n;
        int rows;
        int cols;
        int a;
        int idx;
        m   = BASE << t;
        n   = (4 * BASE) >> t;
        idx = 0;
        for (int op = 0; op < 3; op++) begin
            rows = (op == 1) ? K_DIM : m;
            cols = (op == 0) ? K_DIM : n;
            for (int b = 0; b < NUM_BLK; b++) begin
                for (int r = 0; r < rows; r++) begin
                    for (int c = 0; c < cols; c++) begin
                        a = b * rows * cols + r * cols + c;
`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
                        if (op == 1) a = b * rows * cols + c * K_DIM + r;
`endif
                        exp_q.push_back({2'(op), ADDR_W'(a), dbase + 32'(idx)});
                        idx++;
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] beat(input int k, input logic [1:0] t, input logic [5:0] mp,
                                         input logic [5:0] ap, input logic [31:0] dbase);
        case (k)
            0:       return {30'h15555555, t};
            1:       return {26'h2AAAAAA, mp};
            2:       return {26'h1555555, ap};
            default: return dbase + 32'(k - 3);
        endcase
    endfunction

    task automatic do_start();
        @(negedge clk);
        start    = 1'b1;
        s_wvalid = 1'b1;
        s_wdata  = 32'h3;
        @(negedge clk);
        start    = 1'b0;
        s_wvalid = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic drive(input logic [1:0] t, input logic [5:0] mp, input logic [5:0] ap,
                         input logic [31:0] dbase, input int nbeats, input int gap_pct,
                         input int stop_after);
        int i = 0;
        int cyc = 0;
        while (i < nbeats && i < stop_after) begin
            s_wdata  = beat(i, t, mp, ap, dbase);
            s_wvalid = (gap_pct == 0) || (int'($urandom_range(99)) >= gap_pct);
            if (s_wvalid && s_wready) i++;
            @(negedge clk);
            cyc++;
            if (cyc > nbeats * 4 + 100) begin
                fail("beat_timeout", $sformatf("accepted %0d of %0d beats", i, nbeats));
                break;
            end
        end
        s_wvalid = 1'b0;
    endtask

    task automatic finish_xfer(input logic [1:0] exp_resp, input int hold);
        int cyc = 0;
        if (hold == 0) s_bready = 1'b1;
        while (!s_bvalid && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (!s_bvalid) begin
            fail("resp_timeout", "s_bvalid never rose");
            s_bready = 1'b0;
            return;
        end
        check("bresp", 64'(s_bresp), 64'(exp_resp));
        for (int h = 0; h < hold; h++) begin
            start = (h == 2);
            @(negedge clk);
            check("bvalid_hold", 64'(s_bvalid), 64'(1));
            check("bresp_hold", 64'(s_bresp), 64'(exp_resp));
            check("done_early", 64'(done), 64'(0));
        end
        start    = 1'b0;
        s_bready = 1'b1;
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(1));
        check("bvalid_drop", 64'(s_bvalid), 64'(0));
        @(negedge clk);
        check("done_single", 64'(done), 64'(0));
        check("busy_idle", 64'(busy), 64'(0));
        check("wready_idle", 64'(s_wready), 64'(0));
        s_bready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 64'({busy, done, s_wready, s_bvalid, buf_we}), 64'(0));
        check({tag, "_codes"}, 64'({s_bresp, buf_sel, mat_type}), 64'(0));
        check({tag, "_prec"}, 64'({mul_prec, add_prec}), 64'(0));
        check({tag, "_addr"}, 64'(buf_addr), 64'(0));
        check({tag, "_wdata"}, 64'(buf_wdata), 64'(0));
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rstn && mon_en) begin
            if (done) done_cnt++;
            if (buf_we) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_write", $sformatf("sel %0d addr %0d with no write expected",
                                                       buf_sel, buf_addr));
                end else begin
                    e = exp_q.pop_front();
                    check("write", 64'({buf_sel, buf_addr, buf_wdata}), 64'(e));
                end
                if (buf_sel < 2'd3) begin
                    if (cnt[buf_sel] == 0) first_addr[buf_sel] = buf_addr;
                    last_addr[buf_sel] = buf_addr;
                    cnt[buf_sel]++;
                end
                if (buf_sel == 2'd1 && b_log.size() < 17) b_log.push_back(buf_addr);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");
        mon_en = 1'b1;

        // Type 1 at full rate, s_bready already high when RESP is entered.
        clear_stats();
        build_model(2'd1, 32'h1000_0000);
        s_bready = 1'b1;
        do_start();
        drive(2'd1, 6'd5, 6'd3, 32'h1000_0000, 3 + 3 * 1024, 0, 1 << 30);
        finish_xfer(2'b00, 0);
        check("t1_mul_prec", 64'(mul_prec), 64'(5));
        check("t1_add_prec", 64'(add_prec), 64'(3));
        check("t1_mat_type", 64'(mat_type), 64'(1));
        check("t1_cnt_a", 64'(cnt[0]), 64'(1024));
        check("t1_cnt_b", 64'(cnt[1]), 64'(1024));
        check("t1_cnt_c", 64'(cnt[2]), 64'(1024));
        check("t1_first_a", 64'(first_addr[0]), 64'(0));
        check("t1_last_a", 64'(last_addr[0]), 64'(1023));
        check("t1_last_c", 64'(last_addr[2]), 64'(1023));
        check("t1_done_cnt", 64'(done_cnt), 64'(1));
        check("t1_model_drained", 64'(exp_q.size()), 64'(0));
        if (b_log.size() < 17) begin
            fail("t1_b_log", $sformatf("only %0d B writes seen", b_log.size()));
        end else begin
`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
            check("t1_b_beat1_addr", 64'(b_log[1]), 64'(16));
            check("t1_b_beat16_addr", 64'(b_log[16]), 64'(1));
`else
            check("t1_b_beat1_addr", 64'(b_log[1]), 64'(1));
            check("t1_b_beat16_addr", 64'(b_log[16]), 64'(16));
`endif
        end

        // Type 0 with random s_wvalid gaps and a stalled response with start pulses.
        clear_stats();
        build_model(2'd0, 32'h2000_0000);
        do_start();
        drive(2'd0, 6'h2A, 6'h15, 32'h2000_0000, 3 + 512 + 2048 + 1024, 40, 1 << 30);
        finish_xfer(2'b00, 5);
        check("t0_cnt_a", 64'(cnt[0]), 64'(512));
        check("t0_cnt_b", 64'(cnt[1]), 64'(2048));
        check("t0_cnt_c", 64'(cnt[2]), 64'(1024));
        check("t0_last_b", 64'(last_addr[1]), 64'(2047));
        check("t0_prec", 64'({mul_prec, add_prec}), 64'({6'h2A, 6'h15}));
        check("t0_mat_type", 64'(mat_type), 64'(0));
        check("t0_done_cnt", 64'(done_cnt), 64'(1));
        check("t0_model_drained", 64'(exp_q.size()), 64'(0));

        // Illegal type: one header beat, SLVERR, no writes, precision held from before.
        clear_stats();
        do_start();
        drive(2'd3, 6'd0, 6'd0, 32'h0, 1, 0, 1 << 30);
        check("t3_wready_low", 64'(s_wready), 64'(0));
        check("t3_bvalid", 64'(s_bvalid), 64'(1));
        finish_xfer(2'b10, 0);
        check("t3_mat_type", 64'(mat_type), 64'(3));
        check("t3_no_writes", 64'(cnt[0] + cnt[1] + cnt[2]), 64'(0));
        check("t3_prec_held", 64'({mul_prec, add_prec}), 64'({6'h2A, 6'h15}));
        check("t3_done_cnt", 64'(done_cnt), 64'(1));

        // Reset in the middle of B, then a fresh type 2 transfer.
        clear_stats();
        build_model(2'd1, 32'h3000_0000);
        do_start();
        drive(2'd1, 6'd9, 6'd7, 32'h3000_0000, 3 + 3 * 1024, 0, 3 + 1024 + 100);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("abort");
        check("abort_a_writes", 64'(cnt[0]), 64'(1024));
        check("abort_b_writes", 64'(cnt[1]), 64'(100));
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        clear_stats();
        build_model(2'd2, 32'h4000_0000);
        do_start();
        drive(2'd2, 6'd1, 6'd2, 32'h4000_0000, 3 + 2048 + 512 + 1024, 0, 1 << 30);
        finish_xfer(2'b00, 0);
        check("t2_first_a", 64'(first_addr[0]), 64'(0));
        check("t2_cnt_a", 64'(cnt[0]), 64'(2048));
        check("t2_cnt_b", 64'(cnt[1]), 64'(512));
        check("t2_cnt_c", 64'(cnt[2]), 64'(1024));
        check("t2_mat_type", 64'(mat_type), 64'(2));
        check("t2_model_drained", 64'(exp_q.size()), 64'(0));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
